// File: rtl/pio_spi_loader_if.sv
// Regfile write port between the PIO SPI loader and the 32x16 instruction
// register file: address, data and a one-clock write strobe.
interface pio_spi_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] data_in;
    logic              write_en;

    modport master (output write_addr, output data_in, output write_en);
    modport slave  (input  write_addr, input  data_in, input  write_en);
endinterface

// File: rtl/pio_spi_loader.sv
// SPI mode-0 slave that loads PIO programs into the instruction regfile and gates core_run.
// Optional PIO_SPI_LOADER_AUTOINC_EN: the write address steps by one after every stored word.
module pio_spi_loader #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    pio_spi_loader_if.master wr,
    output logic             core_run,
    output logic             frame_error
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_RUNARG, ST_DISCARD
    } state_e;

    function automatic logic [7:0] status_byte(input logic run, input logic err,
                                               input logic [ADDR_W-1:0] addr);
        logic [4:0] addr5;
        addr5 = 5'(addr);
        return {run, err, 1'b0, addr5};
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]      shift_q, shift_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      write_addr_q, write_addr_d;
    logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
    logic [DATA_W-1:0]      data_in_q, data_in_d;
    logic                   write_en_q, write_en_d;
    logic                   core_run_q, core_run_d;
    logic                   frame_error_q, frame_error_d;
    logic                   miso_q, miso_d;
    logic [6:0]             miso_sr_q, miso_sr_d;

    logic sclk_s, cs_s, mosi_s;
    logic rise_s, fall_s, cs_fall_s, cs_rise_s;
    logic byte_done_s, word_done_s;
    logic [7:0]        byte_s;
    logic [DATA_W-1:0] word_s;
    logic [7:0]        status_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    // SCLK edges only count inside a selected frame.
    assign rise_s      = sclk_s & ~sclk_prev_q & ~cs_s;
    assign fall_s      = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign byte_s      = {shift_q[6:0], mosi_s};
    assign word_s      = {shift_q, mosi_s};
    assign byte_done_s = (bit_cnt_q[2:0] == 3'd7);
    assign word_done_s = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign status_s    = status_byte(core_run_q, frame_error_q, last_addr_q);

    // Synchronizer shift chains for the three SPI pins.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    // Frame decoder, regfile write generation and MISO status shifter.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        addr_d        = addr_q;
        write_addr_d  = write_addr_q;
        last_addr_d   = last_addr_q;
        data_in_d     = data_in_q;
        write_en_d    = 1'b0;
        core_run_d    = core_run_q;
        frame_error_d = frame_error_q;
        miso_d        = miso_q;
        miso_sr_d     = miso_sr_q;
        if (cs_fall_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = {CNT_W{1'b0}};
            shift_d   = {(DATA_W-1){1'b0}};
            miso_d    = status_s[7];
            miso_sr_d = status_s[6:0];
        end else if (cs_rise_s) begin
            // A rise landing together with cs_rise is dropped here; partial fields flag an error.
            if ((bit_cnt_q != {CNT_W{1'b0}}) &&
                ((state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RUNARG))) begin
                frame_error_d = 1'b1;
            end else begin
                frame_error_d = frame_error_q;
            end
            state_d   = ST_IDLE;
            bit_cnt_d = {CNT_W{1'b0}};
            shift_d   = {(DATA_W-1){1'b0}};
            miso_d    = 1'b0;
            miso_sr_d = 7'd0;
        end else if (rise_s && (state_q != ST_IDLE) && (state_q != ST_DISCARD)) begin
            shift_d   = word_s[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            case (state_q)
                ST_CMD: begin
                    if (byte_done_s) begin
                        bit_cnt_d = {CNT_W{1'b0}};
                        case (byte_s)
                            8'h01: begin
                                if (core_run_q) begin
                                    frame_error_d = 1'b1;
                                    state_d       = ST_DISCARD;
                                end else begin
                                    state_d       = ST_ADDR;
                                end
                            end
                            8'h02: state_d = ST_RUNARG;
                            8'h03: begin
                                frame_error_d = 1'b0;
                                state_d       = ST_DISCARD;
                            end
                            default: begin
                                frame_error_d = 1'b1;
                                state_d       = ST_DISCARD;
                            end
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (byte_done_s) begin
                        bit_cnt_d = {CNT_W{1'b0}};
                        addr_d    = byte_s[ADDR_W-1:0];
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (word_done_s) begin
                        bit_cnt_d    = {CNT_W{1'b0}};
                        data_in_d    = word_s;
                        write_addr_d = addr_q;
                        last_addr_d  = addr_q;
                        write_en_d   = 1'b1;
`ifdef PIO_SPI_LOADER_AUTOINC_EN
                        addr_d       = addr_q + ADDR_W'(1);
`else
                        addr_d       = addr_q;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_RUNARG: begin
                    if (byte_done_s) begin
                        bit_cnt_d  = {CNT_W{1'b0}};
                        core_run_d = byte_s[0];
                        state_d    = ST_DISCARD;
                    end else begin
                        state_d = ST_RUNARG;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (fall_s) begin
            miso_d    = miso_sr_q[6];
            miso_sr_d = {miso_sr_q[5:0], 1'b0};
        end else begin
            miso_sr_d = miso_sr_q;
        end
    end

    // All state, registered outputs and synchronizers (idle levels on reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q   <= {SYNC_STAGES{1'b0}};
            cs_sync_q     <= {SYNC_STAGES{1'b1}};
            mosi_sync_q   <= {SYNC_STAGES{1'b0}};
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= {CNT_W{1'b0}};
            shift_q       <= {(DATA_W-1){1'b0}};
            addr_q        <= {ADDR_W{1'b0}};
            write_addr_q  <= {ADDR_W{1'b0}};
            last_addr_q   <= {ADDR_W{1'b0}};
            data_in_q     <= {DATA_W{1'b0}};
            write_en_q    <= 1'b0;
            core_run_q    <= 1'b0;
            frame_error_q <= 1'b0;
            miso_q        <= 1'b0;
            miso_sr_q     <= 7'd0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            write_addr_q  <= write_addr_d;
            last_addr_q   <= last_addr_d;
            data_in_q     <= data_in_d;
            write_en_q    <= write_en_d;
            core_run_q    <= core_run_d;
            frame_error_q <= frame_error_d;
            miso_q        <= miso_d;
            miso_sr_q     <= miso_sr_d;
        end
    end

    assign wr.write_addr = write_addr_q;
    assign wr.data_in    = data_in_q;
    assign wr.write_en   = write_en_q;
    assign core_run      = core_run_q;
    assign frame_error   = frame_error_q;
    assign spi_miso      = miso_q;
endmodule

// File: tb/tb_pio_spi_loader.sv
// Scoreboard bench for pio_spi_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares each write_en; status byte read back over MISO.
module tb_pio_spi_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
`ifdef PIO_SPI_LOADER_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, spi_sclk, spi_cs_n, spi_mosi;
    logic spi_miso, core_run, frame_error;

    pio_spi_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    pio_spi_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .wr          (wr_if),
        .core_run    (core_run),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [20:0] exp_q[$];
    logic [15:0] model_rf[32];
    logic [15:0] dut_rf[32];
    logic        core_run_m, frame_error_m;
    logic [4:0]  last_addr_m;
    logic [7:0]  frm[$];
    logic [7:0]  miso_acc;
    int          miso_n;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_if.write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_write got addr=%0d data=0x%h expected none",
                         wr_if.write_addr, wr_if.data_in);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                if ({wr_if.write_addr, wr_if.data_in} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=0x%h expected addr=%0d data=0x%h",
                             wr_if.write_addr, wr_if.data_in, e[20:16], e[15:0]);
                end
            end
            dut_rf[wr_if.write_addr] = wr_if.data_in;
        end
    end

    // Frame-level reference: what a frame of bytes plus tail bits should do.
    task automatic model_frame(input int tail);
        int         nb;
        int         payload;
        logic [4:0] a;
        nb = frm.size();
        if (nb == 0) return;
        case (frm[0])
            8'h01: begin
                if (core_run_m) begin
                    frame_error_m = 1'b1;
                end else if (nb < 2) begin
                    if (tail != 0) frame_error_m = 1'b1;
                end else begin
                    a = frm[1][4:0];
                    payload = nb - 2;
                    for (int w = 0; w < payload / 2; w++) begin
                        exp_q.push_back({a, frm[2+2*w], frm[3+2*w]});
                        model_rf[a] = {frm[2+2*w], frm[3+2*w]};
                        last_addr_m = a;
                        if (AUTOINC) a = a + 5'd1;
                    end
                    if ((payload % 2) * 8 + tail != 0) frame_error_m = 1'b1;
                end
            end
            8'h02: begin
                if (nb >= 2) core_run_m = frm[1][0];
                else if (tail != 0) frame_error_m = 1'b1;
            end
            8'h03:   frame_error_m = 1'b0;
            default: frame_error_m = 1'b1;
        endcase
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input int half);
        for (int k = n - 1; k >= 0; k--) begin
            spi_mosi = v[k];
            #(half * 10);
            spi_sclk = 1'b1;
            #(half * 10 - 1);
            if (miso_n < 8) begin
                miso_acc = {miso_acc[6:0], spi_miso};
                miso_n++;
            end
            #1;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int tail, input int half);
        logic [7:0] exp_st;
        exp_st = {core_run_m, frame_error_m, 1'b0, last_addr_m};
        model_frame(tail);
        @(posedge clk);
        #($urandom_range(1, 4));
        miso_acc = 8'h00;
        miso_n = 0;
        spi_cs_n = 1'b0;
        #80;
        foreach (frm[i]) send_bits({8'h00, frm[i]}, 8, half);
        if (tail > 0) send_bits(16'($urandom), tail, half);
        #40;
        spi_cs_n = 1'b1;
        #80;
        if (half >= 4 && miso_n == 8) check("miso_status", 32'(miso_acc), 32'(exp_st));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("frame_error", 32'(frame_error), 32'(frame_error_m));
        check("core_run", 32'(core_run), 32'(core_run_m));
        check("miso_idle", 32'(spi_miso), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        int          nw;
        rst = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        core_run_m = 1'b0;
        frame_error_m = 1'b0;
        last_addr_m = 5'd0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 16'h0000;
            dut_rf[i] = 16'h0000;
        end
        #23;
        check("rst_write_en", 32'(wr_if.write_en), 32'd0);
        check("rst_write_addr", 32'(wr_if.write_addr), 32'd0);
        check("rst_data_in", 32'(wr_if.data_in), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        rst = 1'b1;
        #40;

        frm = {8'h01, 8'h03, 8'hA5, 8'hC3};
        run_frame(0, 4);
        check("t1_data", 32'(wr_if.data_in), 32'h0000A5C3);
        check("t1_addr", 32'(wr_if.write_addr), 32'd3);

        frm = {8'h01, 8'h1F, 8'h11, 8'h11, 8'h22, 8'h22};
        run_frame(0, 4);
        check("t2_data", 32'(wr_if.data_in), 32'h00002222);
        check("t2_addr", 32'(wr_if.write_addr), AUTOINC ? 32'd0 : 32'd31);

        frm = {8'h01, 8'h04, 8'hA5};
        run_frame(1, 4);
        check("t3_abort_err", 32'(frame_error), 32'd1);
        frm = {8'h03};
        run_frame(0, 4);
        check("t3_clear", 32'(frame_error), 32'd0);

        frm = {8'h02, 8'h01};
        run_frame(0, 4);
        check("t4_run", 32'(core_run), 32'd1);
        frm = {8'h01, 8'h00, 8'hFF, 8'hFF};
        run_frame(0, 4);
        check("t4_lockout_err", 32'(frame_error), 32'd1);
        frm = {8'h03};
        run_frame(0, 5);
        check("t4_status", 32'(miso_acc), AUTOINC ? 32'hC0 : 32'hDF);
        frm = {8'h02, 8'h00};
        run_frame(0, 4);

        frm = {8'h7E, 8'h01, 8'h05, 8'h12, 8'h34};
        run_frame(0, 4);
        check("t5_badcmd", 32'(frame_error), 32'd1);

        // Reset mid-word: outputs clear asynchronously and no write follows.
        @(posedge clk);
        #3;
        spi_cs_n = 1'b0;
        #80;
        miso_n = 8;
        send_bits(16'h0001, 8, 2);
        send_bits(16'h0005, 8, 2);
        send_bits(16'h0155, 9, 2);
        #13;
        rst = 1'b0;
        #1;
        check("rst_mid_write_en", 32'(wr_if.write_en), 32'd0);
        check("rst_mid_addr", 32'(wr_if.write_addr), 32'd0);
        check("rst_mid_data", 32'(wr_if.data_in), 32'd0);
        check("rst_mid_err", 32'(frame_error), 32'd0);
        check("rst_mid_run", 32'(core_run), 32'd0);
        check("rst_mid_miso", 32'(spi_miso), 32'd0);
        #30;
        spi_cs_n = 1'b1;
        #50;
        rst = 1'b1;
        core_run_m = 1'b0;
        frame_error_m = 1'b0;
        last_addr_m = 5'd0;
        #100;

        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            frm = {8'(($urandom_range(0, 7) << 5) | i), d[15:8], d[7:0]};
            frm.push_front(8'h01);
            run_frame(0, 2);
        end
        for (int i = 0; i < 6; i++) begin
            frm = {8'h01, 8'($urandom)};
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                d = 16'($urandom);
                frm.push_back(d[15:8]);
                frm.push_back(d[7:0]);
            end
            run_frame(0, $urandom_range(2, 3));
        end
        #200;
        for (int i = 0; i < 32; i++) check("regfile", 32'(dut_rf[i]), 32'(model_rf[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
